scalar_reg_unit: RTL and testbench

Execute stage for the scalar loop registers of the vector ASIP. Consumes the `sca_reg_op`/`imm` pair produced by the ID-stage instruction decoder and maintains the loop indices `i`, `j` and the loop bound `n` used by the vector datapath. Signals index wrap-around, loop completion and illegal operations, and applies back-pressure while a new bound is loaded.

---
 rtl/scalar_reg_unit.sv | 127 ++++++++++++
 tb/tb_scalar_reg_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/scalar_reg_unit.sv
// Loop-index execute stage: tracks i/j against bound n, flags wraps, loop end and illegal ops.
// Outputs are registered; a SETN stalls the op stream for one LOAD cycle while the new bound is applied.
module scalar_reg_unit #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         op_valid,
  input  logic [1:0]   sca_reg_op,
  input  logic [W-1:0] imm,
  output logic         op_ready,
  output logic [W-1:0] i_out,
  output logic [W-1:0] j_out,
  output logic [W-1:0] n_out,
  output logic         i_wrap,
  output logic         j_wrap,
  output logic         loop_done,
  output logic         op_err
);

  typedef enum logic [1:0] {UNCFG, LOAD, RUN, DONE} state_t;

  localparam logic [1:0]   OP_INCRI = 2'b00;
  localparam logic [1:0]   OP_INCRJ = 2'b01;
  localparam logic [1:0]   OP_SETN  = 2'b10;
  localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};

  state_t       state, state_nxt;
  logic [W-1:0] pend, pend_nxt;
  logic [W-1:0] i_nxt, j_nxt, n_nxt;
  logic         iw_nxt, jw_nxt, err_nxt, done_nxt, ready_nxt;
  logic         accept;
  logic [W-1:0] last;

  assign accept = op_valid && op_ready;
  assign last   = n_out - ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= UNCFG;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    i_nxt     = i_out;
    j_nxt     = j_out;
    n_nxt     = n_out;
    iw_nxt    = 1'b0;
    jw_nxt    = 1'b0;
    err_nxt   = 1'b0;
    done_nxt  = loop_done;
    case (state)
      LOAD: begin
        n_nxt     = pend;
        i_nxt     = '0;
        j_nxt     = '0;
        done_nxt  = 1'b0;
        state_nxt = RUN;
      end
      default: begin
        if (accept) begin
          case (sca_reg_op)
            OP_SETN: begin
              if (imm == '0) begin
                err_nxt = 1'b1;
              end else begin
                pend_nxt  = imm;
                state_nxt = LOAD;
              end
            end
            // Index ops are only meaningful inside an active loop.
            OP_INCRI: begin
              if (state != RUN) begin
                err_nxt = 1'b1;
              end else if (i_out == last) begin
                i_nxt  = '0;
                iw_nxt = 1'b1;
              end else begin
                i_nxt = i_out + ONE;
              end
            end
            OP_INCRJ: begin
              if (state != RUN) begin
                err_nxt = 1'b1;
              end else if (j_out == last) begin
                j_nxt     = '0;
                jw_nxt    = 1'b1;
                done_nxt  = 1'b1;
                state_nxt = DONE;
              end else begin
                j_nxt = j_out + ONE;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
    ready_nxt = (state_nxt != LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= '0;
      i_out     <= '0;
      j_out     <= '0;
      n_out     <= '0;
      i_wrap    <= 1'b0;
      j_wrap    <= 1'b0;
      op_err    <= 1'b0;
      loop_done <= 1'b0;
      op_ready  <= 1'b1;
    end else begin
      pend      <= pend_nxt;
      i_out     <= i_nxt;
      j_out     <= j_nxt;
      n_out     <= n_nxt;
      i_wrap    <= iw_nxt;
      j_wrap    <= jw_nxt;
      op_err    <= err_nxt;
      loop_done <= done_nxt;
      op_ready  <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_scalar_reg_unit.sv
// Directed and randomized checks of scalar_reg_unit against a modular-arithmetic reference model.
module tb_scalar_reg_unit;
  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         op_valid = 1'b0;
  logic [1:0]   sca_reg_op = 2'b11;
  logic [W-1:0] imm = '0;
  logic         op_ready, i_wrap, j_wrap, loop_done, op_err;
  logic [W-1:0] i_out, j_out, n_out;

  scalar_reg_unit #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .sca_reg_op(sca_reg_op), .imm(imm),
    .op_ready(op_ready), .i_out(i_out), .j_out(j_out), .n_out(n_out),
    .i_wrap(i_wrap), .j_wrap(j_wrap), .loop_done(loop_done), .op_err(op_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: "configured", "loading" and "done" flags plus plain integer indices.
  bit          m_cfg, m_load, m_done, m_iw, m_jw, m_err;
  int unsigned m_n, m_i, m_j, m_pend;

  bit           r_v;
  logic [1:0]   r_op;
  logic [W-1:0] r_imm;
  int           r_sel;
  int           exp_i[5];
  int           exp_w[5];
  int           exp_j[3];

  always @(posedge clk) begin
    assert (!(rst_n === 1'b1 && op_valid === 1'b1 && $isunknown(sca_reg_op))) else begin
      errors++;
      $error("FAIL proto_x observed=%b required=known", sca_reg_op);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cfg = 0; m_load = 0; m_done = 0; m_iw = 0; m_jw = 0; m_err = 0;
    m_n = 0; m_i = 0; m_j = 0; m_pend = 0;
  endtask

  // Advance the model by one clock edge using the inputs presented at that edge.
  task automatic model_edge();
    m_iw = 0; m_jw = 0; m_err = 0;
    if (m_load) begin
      m_n = m_pend; m_i = 0; m_j = 0; m_done = 0; m_load = 0; m_cfg = 1;
    end else if (op_valid) begin
      case (sca_reg_op)
        2'b10: if (imm == 0) m_err = 1; else begin m_pend = imm; m_load = 1; end
        2'b00: if (!m_cfg || m_done) m_err = 1;
               else begin m_i = (m_i + 1) % m_n; m_iw = (m_i == 0); end
        2'b01: if (!m_cfg || m_done) m_err = 1;
               else begin
                 m_j = (m_j + 1) % m_n;
                 if (m_j == 0) begin m_jw = 1; m_done = 1; end
               end
        default: ;
      endcase
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".i_out"},     i_out,     m_i);
    chk({ctx, ".j_out"},     j_out,     m_j);
    chk({ctx, ".n_out"},     n_out,     m_n);
    chk({ctx, ".i_wrap"},    i_wrap,    m_iw);
    chk({ctx, ".j_wrap"},    j_wrap,    m_jw);
    chk({ctx, ".loop_done"}, loop_done, m_done);
    chk({ctx, ".op_err"},    op_err,    m_err);
    chk({ctx, ".op_ready"},  op_ready,  !m_load);
  endtask

  task automatic step(input bit v, input logic [1:0] op, input logic [W-1:0] im, input string ctx);
    op_valid = v; sca_reg_op = op; imm = im;
    @(posedge clk);
    #1;
    model_edge();
    check_all(ctx);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    step(1, 2'b00, '0, "uncfg_incri");
    chk("uncfg_incri_err", op_err, 1);
    chk("uncfg_incri_i", i_out, 0);
    step(1, 2'b10, '0, "uncfg_setn0");
    chk("uncfg_setn0_err", op_err, 1);

    exp_i = '{1, 2, 3, 0, 1};
    exp_w = '{0, 0, 0, 1, 0};
    step(1, 2'b10, 24'd4, "setn4");
    chk("setn4_ready_low", op_ready, 0);
    step(0, 2'b11, '0, "load4");
    chk("load4_ready", op_ready, 1);
    chk("load4_n", n_out, 4);
    for (int k = 0; k < 5; k++) begin
      step(1, 2'b00, '0, "incri4");
      chk("incri4_i", i_out, exp_i[k]);
      chk("incri4_wrap", i_wrap, exp_w[k]);
    end

    step(1, 2'b00, '0, "pre_rst");
    step(1, 2'b00, '0, "pre_rst");
    chk("pre_rst_i", i_out, 3);
    op_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_i", i_out, 0);
    chk("async_rst_n", n_out, 0);
    chk("async_rst_ready", op_ready, 1);
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    exp_j = '{1, 2, 0};
    step(1, 2'b10, 24'd3, "setn3");
    step(0, 2'b11, '0, "load3");
    for (int k = 0; k < 3; k++) begin
      step(1, 2'b01, '0, "incrj3");
      chk("incrj3_j", j_out, exp_j[k]);
    end
    chk("incrj3_jwrap", j_wrap, 1);
    chk("incrj3_done", loop_done, 1);
    step(1, 2'b01, '0, "done_incrj");
    chk("done_incrj_err", op_err, 1);
    chk("done_incrj_j", j_out, 0);
    step(1, 2'b00, '0, "done_incri");
    chk("done_incri_err", op_err, 1);

    step(1, 2'b10, 24'd5, "setn5");
    step(1, 2'b11, '0, "load5");
    step(1, 2'b00, '0, "run5_incri");
    step(1, 2'b10, '0, "run5_setn0");
    chk("run5_setn0_err", op_err, 1);
    chk("run5_setn0_n", n_out, 5);

    step(1, 2'b10, 24'd2, "bp_setn");
    step(1, 2'b00, '0, "bp_stall");
    chk("bp_stall_i", i_out, 0);
    step(1, 2'b00, '0, "bp_accept");
    chk("bp_accept_i", i_out, 1);

    step(1, 2'b10, 24'd7, "rnd_setn");
    r_v = 1'b0; r_op = 2'b11; r_imm = '0;
    for (int k = 0; k < 1000; k++) begin
      if (!(m_load && r_v)) begin
        r_v = ($urandom_range(0, 9) < 7);
        r_sel = $urandom_range(0, 19);
        r_imm = W'($urandom);
        if (r_sel < 2) begin
          r_op = 2'b10;
          case ($urandom_range(0, 3))
            0: r_imm = '0;
            1: r_imm = 24'd1;
            2: r_imm = 24'd2;
            default: r_imm = 24'd7;
          endcase
        end else if (r_sel < 9) r_op = 2'b00;
        else if (r_sel < 16) r_op = 2'b01;
        else r_op = 2'b11;
      end
      step(r_v, r_op, r_imm, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
